// File: rtl/sub_flags_stage_pkg.sv
// Shared constants and types for the subtractor result/flag stage.
package sub_flags_stage_pkg;

    // Default datapath width; must match the upstream ripple subtractor.
    localparam int W_DEFAULT = 8;

    // Bit positions of the per-byte flags inside the 4-bit flag field.
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Payload = {last, zc, flags[3:0], diff[W-1:0]}.
    localparam int PAYLOAD_W = W_DEFAULT + 6;

    // Payload width for an arbitrary data width.
    function automatic int payload_width(input int w);
        return w + 6;
    endfunction

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/sub_flags_stage_if.sv
// Handshake and data bundle between subtractor, flag stage and downstream.
interface sub_flags_stage_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W:0]   in_diff;
    logic         in_first;
    logic         in_last;
    logic         borrow_fb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_n;
    logic         out_z;
    logic         out_c;
    logic         out_v;
    logic         out_zc;
    logic         out_last;

    // Upstream subtractor and downstream consumer side.
    modport master (
        output in_valid, in_a, in_b, in_diff, in_first, in_last, out_ready,
        input  in_ready, borrow_fb, out_valid, out_diff,
               out_n, out_z, out_c, out_v, out_zc, out_last
    );

    // Flag stage side.
    modport slave (
        input  in_valid, in_a, in_b, in_diff, in_first, in_last, out_ready,
        output in_ready, borrow_fb, out_valid, out_diff,
               out_n, out_z, out_c, out_v, out_zc, out_last
    );
endinterface

// File: rtl/sub_flags_stage_skid_buf2.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs
// one extra beat so the upstream ready can be registered.
module skid_buf2
    import sub_flags_stage_pkg::*;
#(
    parameter int PW = PAYLOAD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    buf_state_t    state_reg;
    logic [PW-1:0] main_reg;
    logic [PW-1:0] skid_reg;
    logic          in_ready_reg;
    logic          accept;
    logic          push;

    assign accept    = in_valid & in_ready_reg;
    assign out_valid = (state_reg != BUF_EMPTY);
    assign push      = out_valid & out_ready;
    assign in_ready  = in_ready_reg;
    assign out_data  = main_reg;

    // Occupancy FSM; in_ready is registered as "next state is not FULL".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BUF_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_reg  <= in_data;
                        state_reg <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && push) begin
                        main_reg <= in_data;
                    end else if (accept) begin
                        skid_reg     <= in_data;
                        state_reg    <= BUF_FULL;
                        in_ready_reg <= 1'b0;
                    end else if (push) begin
                        state_reg <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so no accept can occur.
                    if (push) begin
                        main_reg     <= skid_reg;
                        state_reg    <= BUF_ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= BUF_EMPTY;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sub_flags_stage.sv
// Registered result/flag stage behind the ripple subtractor: derives N/Z/C/V,
// tracks chain-zero and chain-borrow, and buffers results in a skid buffer.
module sub_flags_stage
    import sub_flags_stage_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    sub_flags_stage_if.slave bus
);

    localparam int PW = payload_width(W);

    logic [W-1:0]  diff_lo;
    logic [3:0]    flags;
    logic          zc;
    logic          accept;
    logic          zacc_reg;
    logic          borrow_reg;
    logic          buf_in_ready;
    logic          buf_out_valid;
    logic [PW-1:0] pay_in;
    logic [PW-1:0] pay_out;
    logic          unused_bits;

    // Only the sign bits of the operands matter for overflow detection.
    assign unused_bits = ^{bus.in_a[W-2:0], bus.in_b[W-2:0]};

    assign diff_lo = bus.in_diff[W-1:0];
    assign accept  = bus.in_valid & buf_in_ready;

    // Per-byte flags and running chain-zero, from the inputs at accept time.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = bus.in_diff[W-1];
        flags[FLAG_Z] = (diff_lo == '0);
        flags[FLAG_C] = bus.in_diff[W];
        flags[FLAG_V] = (bus.in_a[W-1] ^ bus.in_b[W-1]) &
                        (bus.in_a[W-1] ^ bus.in_diff[W-1]);
        zc            = (bus.in_first | zacc_reg) & flags[FLAG_Z];
    end

    // Chain state: a last byte closes the chain and restores the idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            zacc_reg   <= 1'b1;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            zacc_reg   <= bus.in_last ? 1'b1 : zc;
            borrow_reg <= bus.in_last ? 1'b0 : flags[FLAG_C];
        end
    end

    assign pay_in = {bus.in_last, zc, flags, diff_lo};

    skid_buf2 #(
        .PW(PW)
    ) u_skid_buf2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (pay_in),
        .out_valid (buf_out_valid),
        .out_ready (bus.out_ready),
        .out_data  (pay_out)
    );

    assign bus.in_ready  = buf_in_ready;
    assign bus.borrow_fb = borrow_reg;
    assign bus.out_valid = buf_out_valid;
    assign bus.out_diff  = pay_out[W-1:0];
    assign bus.out_n     = pay_out[W + FLAG_N];
    assign bus.out_z     = pay_out[W + FLAG_Z];
    assign bus.out_c     = pay_out[W + FLAG_C];
    assign bus.out_v     = pay_out[W + FLAG_V];
    assign bus.out_zc    = pay_out[W + 4];
    assign bus.out_last  = pay_out[W + 5];

endmodule

// File: tb/tb_sub_flags_stage.sv
// Directed testbench for sub_flags_stage: flags, chaining, backpressure, reset.
module tb_sub_flags_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sub_flags_stage_if #(.W(8)) bus ();

    sub_flags_stage #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat on the input side (held until the caller changes it).
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [8:0] d,
                         input logic first, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_diff  = d;
        bus.in_first = first;
        bus.in_last  = last;
    endtask

    // Output payload as {last, zc, V, C, Z, N, diff}.
    function automatic logic [31:0] outw();
        return {18'd0, bus.out_last, bus.out_zc, bus.out_v, bus.out_c,
                bus.out_z, bus.out_n, bus.out_diff};
    endfunction

    function automatic logic [31:0] expw(input logic last, input logic zc, input logic v,
                                         input logic c, input logic z, input logic n,
                                         input logic [7:0] d);
        return {18'd0, last, zc, v, c, z, n, d};
    endfunction

    // Single accepted beat with out_ready=1; checks the output one edge later.
    task automatic one_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] d, input logic first, input logic last,
                            input logic [31:0] exp_out, input logic exp_bfb);
        drive(a, b, d, first, last);
        cyc();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_out"}, outw(), exp_out);
        check({tag, "_bfb"}, {31'd0, bus.borrow_fb}, {31'd0, exp_bfb});
        $display("txn %s a=%02h b=%02h diff=%03h out=%05h bfb=%0b", tag, a, b, d, outw(), bus.borrow_fb);
        cyc(); // buffer drains
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_diff = '0;
        bus.in_first = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state.
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_bfb",   {31'd0, bus.borrow_fb}, 32'd0);
        check("rst_out",   outw(), 32'd0);
        cyc();

        // Basic, borrow/negative, signed overflow.
        one_beat("basic", 8'h05, 8'h03, 9'h002, 1'b1, 1'b1, expw(1, 0, 0, 0, 0, 0, 8'h02), 1'b0);
        one_beat("neg",   8'h03, 8'h05, 9'h1FE, 1'b1, 1'b1, expw(1, 0, 0, 1, 0, 1, 8'hFE), 1'b0);
        one_beat("ovf",   8'h80, 8'h01, 9'h07F, 1'b1, 1'b1, expw(1, 0, 1, 0, 0, 0, 8'h7F), 1'b0);
        check("drained", {31'd0, bus.out_valid}, 32'd0);

        // Two-byte chain ending in zero.
        one_beat("ch1_b1", 8'h00, 8'h00, 9'h100, 1'b1, 1'b0, expw(0, 1, 0, 1, 1, 0, 8'h00), 1'b1);
        one_beat("ch1_b2", 8'h01, 8'h00, 9'h000, 1'b0, 1'b1, expw(1, 1, 0, 0, 1, 0, 8'h00), 1'b0);
        // Same chain with nonzero upper byte.
        one_beat("ch2_b1", 8'h00, 8'h00, 9'h100, 1'b1, 1'b0, expw(0, 1, 0, 1, 1, 0, 8'h00), 1'b1);
        one_beat("ch2_b2", 8'h02, 8'h00, 9'h001, 1'b0, 1'b1, expw(1, 0, 0, 0, 0, 0, 8'h01), 1'b0);
        // zacc must have returned to 1: a non-first zero byte yields zc=1.
        one_beat("zacc",   8'h01, 8'h00, 9'h000, 1'b0, 1'b1, expw(1, 1, 0, 0, 1, 0, 8'h00), 1'b0);

        // Backpressure: 0x11, 0x22, 0x33 with out_ready held low.
        bus.out_ready = 1'b0;
        drive(8'h11, 8'h00, 9'h011, 1'b1, 1'b1);
        cyc();
        check("bp1_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp1_out", {24'd0, bus.out_diff}, 32'h11);
        drive(8'h22, 8'h00, 9'h022, 1'b1, 1'b1);
        cyc();
        check("bp2_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp2_out", {24'd0, bus.out_diff}, 32'h11);
        drive(8'h33, 8'h00, 9'h033, 1'b1, 1'b1);
        cyc();
        check("bp3_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp3_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp3_stable", {24'd0, bus.out_diff}, 32'h11);
        $display("txn bp_hold out=%02h in_ready=%0b", bus.out_diff, bus.in_ready);
        bus.out_ready = 1'b1;
        cyc();
        check("bp4_out", {24'd0, bus.out_diff}, 32'h22);
        check("bp4_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("txn bp_rel1 out=%02h", bus.out_diff);
        cyc();
        bus.in_valid = 1'b0;
        check("bp5_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp5_out", {24'd0, bus.out_diff}, 32'h33);
        $display("txn bp_rel2 out=%02h", bus.out_diff);
        cyc();
        check("bp6_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-chain with the buffer FULL.
        bus.out_ready = 1'b0;
        drive(8'h00, 8'h00, 9'h100, 1'b1, 1'b0);
        cyc();
        drive(8'h00, 8'h00, 9'h105, 1'b0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        check("full_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_bfb", {31'd0, bus.borrow_fb}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst_bfb", {31'd0, bus.borrow_fb}, 32'd0);
        check("mrst_out", outw(), 32'd0);
        $display("txn mid_reset valid=%0b ready=%0b bfb=%0b", bus.out_valid, bus.in_ready, bus.borrow_fb);
        cyc();
        check("mrst_valid2", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        one_beat("post_rst", 8'h07, 8'h07, 9'h000, 1'b0, 1'b1, expw(1, 1, 0, 0, 1, 0, 8'h00), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub_flags_stage.md
# sub_flags_stage

Registered result/flag stage directly downstream of the 8-bit ripple subtractor.
- Captures the subtractor's difference and borrow, derives N/Z/C/V flags, and tracks zero and borrow across multi-byte subtract chains.
- Presents results through a valid/ready handshake backed by a 2-entry skid buffer, so the subtractor path runs at full throughput under backpressure.
- The registered borrow feeds the subtractor's `cin` for the next byte of a chain.

## Interface
Parameters:
- `W`, default 8. Data width; must match the subtractor width.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_valid`: input, 1 bit. Upstream result valid.
- `in_ready`: output, 1 bit. Stage can accept a result; registered.
- `in_a`: input, `W` bits. Minuend presented to the subtractor.
- `in_b`: input, `W` bits. Subtrahend presented to the subtractor.
- `in_diff`: input, `W+1` bits. Subtractor output; `[W]` is borrow-out.
- `in_first`: input, 1 bit. This byte starts a chain.
- `in_last`: input, 1 bit. This byte ends a chain. A single-byte operation has both `in_first` and `in_last` set.
- `borrow_fb`: output, 1 bit. Registered chain borrow; drives the subtractor `cin`.
- `out_valid`: output, 1 bit. Output entry valid.
- `out_ready`: input, 1 bit. Downstream accepts.
- `out_diff`: output, `W` bits. Difference.
- `out_n`: output, 1 bit. Negative flag.
- `out_z`: output, 1 bit. This byte is zero.
- `out_c`: output, 1 bit. Borrow flag.
- `out_v`: output, 1 bit. Signed overflow.
- `out_zc`: output, 1 bit. Chain-zero: all bytes of the chain so far are zero.
- `out_last`: output, 1 bit. Copy of `in_last`.

## Operation
- Accept occurs when `in_valid & in_ready`. Push occurs when `out_valid & out_ready`.
- Flags are computed combinationally from the inputs at accept time:
  - N = `in_diff[W-1]`
  - Z = (`in_diff[W-1:0]` == 0)
  - C = `in_diff[W]`
  - V = (`in_a[W-1]` ^ `in_b[W-1]`) & (`in_a[W-1]` ^ `in_diff[W-1]`)
  - All arithmetic is unsigned `W+1`-bit; no sign extension.
- Chain state consists of `zacc` (reset 1) and `borrow_fb` (reset 0). On accept:
  - zc = (`in_first` ? 1 : `zacc`) & Z
  - `zacc` <= `in_last` ? 1 : zc
  - `borrow_fb` <= `in_last` ? 0 : C
- `in_first` overrides `borrow_fb` history. The subtractor is driven with `cin` = `borrow_fb` except on a first byte, where upstream forces 0. This stage only supplies the register.
- The payload {diff, N, Z, C, V, zc, last} is written to the skid buffer. The buffer has two entries, main and skid; `out_*` always reflects main.
- Buffer transitions, by state:
  - EMPTY, accept: write main; next state ONE.
  - ONE, accept and push: overwrite main; stay ONE.
  - ONE, push only: go to EMPTY.
  - ONE, accept only: write skid; go to FULL.
  - FULL, push: move skid to main; go to ONE.
  - FULL: `in_valid` is ignored, because `in_ready` is 0.
- `in_ready` = (next state != FULL), registered. `out_valid` = (state != EMPTY).
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency is 1 cycle: accept at edge k gives `out_valid`=1 after edge k.
- Throughput is 1 result/cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid entry fills. It rises the cycle after a push from FULL.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `borrow_fb`=0, `zacc`=1.
  - `out_diff` and all flags = 0.
  - State = EMPTY.
- Reset mid-chain or mid-backpressure discards all buffered entries and chain state. There is no output activity on the reset cycle or the cycle after.
- `out_*` data must remain stable while `out_valid & ~out_ready`.
- Simultaneous accept and push in ONE: the new data is visible on the next cycle; `in_ready` stays 1.

## Structure
- A shared package/header holds:
  - default `W`
  - flag bit indices `FLAG_N`=0, `FLAG_Z`=1, `FLAG_C`=2, `FLAG_V`=3
  - payload width constant `W+6`
- One sub-module, `skid_buf2`, is parameterised by payload width. It owns the EMPTY/ONE/FULL state and the main/skid registers.
- Flag logic and the chain registers live in `sub_flags_stage`.

## Test plan
- Basic subtraction, first=last=1: a=0x05, b=0x03, diff=0x002 -> out_diff=0x02, N0 Z0 C0 V0, zc0, `borrow_fb` stays 0.
- Borrow and negative: a=0x03, b=0x05, diff=0x1FE -> out_diff=0xFE, N1 Z0 C1 V0.
- Signed overflow: a=0x80, b=0x01, diff=0x07F -> N0 C0 V1.
- Two-byte chain:
  - Byte 1 (first): diff=0x100 -> `borrow_fb`=1 next cycle, zc=1.
  - Byte 2 (last): diff=0x000 -> zc=1, `borrow_fb` returns to 0, `zacc` returns to 1.
  - Repeat with byte 2 diff=0x001 -> zc=0.
- Backpressure: hold `out_ready`=0 and push 0x11, 0x22, 0x33 back-to-back.
  - `in_ready` drops after 0x22; 0x33 is held upstream.
  - Release `out_ready` -> 0x11, 0x22, 0x33 emerge in order on consecutive cycles.
- Reset mid-chain in FULL: assert `rst` for 1 cycle -> `out_valid`=0, `in_ready`=1, `borrow_fb`=0. The next single byte gives correct zc.
